// File: rtl/ip_merge.sv
// ip_merge: packet-atomic merge of TCP and UDP word streams into one registered IP stream
// Ports:
//   clk, reset (asynchronous, active-low)
//   tcp_data_in/valid/last -> tcp_data_ready : TCP source stream
//   udp_data_in/valid/last -> udp_data_ready : UDP source stream
//   ip_data_out/valid/last <- ip_data_ready  : registered merged output stream
//   tcp_pkt_cnt, udp_pkt_cnt                 : 16-bit packet counters, present only with IP_MERGE_PKT_CNT_EN
module ip_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tcp_data_in,
    input  logic                  tcp_data_valid,
    input  logic                  tcp_data_last,
    output logic                  tcp_data_ready,
    input  logic [DATA_WIDTH-1:0] udp_data_in,
    input  logic                  udp_data_valid,
    input  logic                  udp_data_last,
    output logic                  udp_data_ready,
    output logic [DATA_WIDTH-1:0] ip_data_out,
    output logic                  ip_data_valid,
    output logic                  ip_data_last,
    input  logic                  ip_data_ready
`ifdef IP_MERGE_PKT_CNT_EN
    ,
    output logic [15:0]           tcp_pkt_cnt,
    output logic [15:0]           udp_pkt_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, TCP_PKT, UDP_PKT} state_t;
    state_t state, next_state;
    logic last_served, free, tcp_sel, udp_sel, tcp_acc, udp_acc;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= next_state;
    end
    // last_served: 0 = TCP, 1 = UDP; on a tie in IDLE the other source wins
    always_comb begin
        free           = !ip_data_valid || ip_data_ready;
        tcp_sel        = (state == TCP_PKT) ||
                         (state == IDLE && tcp_data_valid && (!udp_data_valid || last_served));
        udp_sel        = (state == UDP_PKT) ||
                         (state == IDLE && udp_data_valid && (!tcp_data_valid || !last_served));
        tcp_data_ready = free && tcp_sel;
        udp_data_ready = free && udp_sel;
        tcp_acc        = tcp_data_ready && tcp_data_valid;
        udp_acc        = udp_data_ready && udp_data_valid;
        next_state     = tcp_acc ? (tcp_data_last ? IDLE : TCP_PKT) :
                         udp_acc ? (udp_data_last ? IDLE : UDP_PKT) : state;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ip_data_out   <= '0;
            ip_data_valid <= 1'b0;
            ip_data_last  <= 1'b0;
            last_served   <= 1'b1;
        end else begin
            if (tcp_acc || udp_acc) begin
                ip_data_out   <= tcp_acc ? tcp_data_in : udp_data_in;
                ip_data_last  <= tcp_acc ? tcp_data_last : udp_data_last;
                ip_data_valid <= 1'b1;
            end else if (ip_data_ready) begin
                ip_data_valid <= 1'b0;
            end
            if ((tcp_acc && tcp_data_last) || (udp_acc && udp_data_last)) last_served <= udp_acc;
        end
    end
`ifdef IP_MERGE_PKT_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcp_pkt_cnt <= '0;
            udp_pkt_cnt <= '0;
        end else begin
            if (tcp_acc && tcp_data_last) tcp_pkt_cnt <= tcp_pkt_cnt + 16'd1;
            if (udp_acc && udp_data_last) udp_pkt_cnt <= udp_pkt_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ip_merge.sv
// tb_ip_merge: self-checking bench for ip_merge (directed steps plus randomized packet traffic)
module tb_ip_merge;
    localparam int W = 32;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  tcp_data_in = '0, udp_data_in = '0, ip_data_out;
    logic          tcp_data_valid = 1'b0, tcp_data_last = 1'b0, tcp_data_ready;
    logic          udp_data_valid = 1'b0, udp_data_last = 1'b0, udp_data_ready;
    logic          ip_data_valid, ip_data_last, ip_data_ready = 1'b0;
`ifdef IP_MERGE_PKT_CNT_EN
    logic [15:0]   tcp_pkt_cnt, udp_pkt_cnt;
`endif
    int            n_chk = 0, n_fail = 0;
    bit            m_last = 1'b1;
    logic [W-1:0]  tq_d[$], uq_d[$], exp_d[$];
    bit            tq_l[$], uq_l[$], exp_l[$];
    int            tlen[$], ulen[$];

    always #5 clk = ~clk;

    ip_merge #(.DATA_WIDTH(W)) dut (
`ifdef IP_MERGE_PKT_CNT_EN
        .tcp_pkt_cnt(tcp_pkt_cnt),
        .udp_pkt_cnt(udp_pkt_cnt),
`endif
        .clk(clk), .reset(reset),
        .tcp_data_in(tcp_data_in), .tcp_data_valid(tcp_data_valid),
        .tcp_data_last(tcp_data_last), .tcp_data_ready(tcp_data_ready),
        .udp_data_in(udp_data_in), .udp_data_valid(udp_data_valid),
        .udp_data_last(udp_data_last), .udp_data_ready(udp_data_ready),
        .ip_data_out(ip_data_out), .ip_data_valid(ip_data_valid),
        .ip_data_last(ip_data_last), .ip_data_ready(ip_data_ready)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit tv, input logic [W-1:0] td, input bit tl,
                         input bit uv, input logic [W-1:0] ud, input bit ul, input bit ir);
        @(negedge clk);
        tcp_data_valid = tv; tcp_data_in = td; tcp_data_last = tl;
        udp_data_valid = uv; udp_data_in = ud; udp_data_last = ul;
        ip_data_ready  = ir;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        tcp_data_valid = 1'b0; udp_data_valid = 1'b0; ip_data_ready = 1'b0;
        m_last = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic add_pkt(input bit udp, input int len);
        logic [W-1:0] d;
        for (int i = 0; i < len; i++) begin
            d = $urandom;
            if (udp) begin uq_d.push_back(d); uq_l.push_back(i == len - 1); end
            else begin tq_d.push_back(d); tq_l.push_back(i == len - 1); end
        end
        if (udp) ulen.push_back(len); else tlen.push_back(len);
    endtask

    // Reference order: whole packets, alternating on contention, starting with the source not last served
    task automatic plan();
        int to = 0, uo = 0, ti = 0, ui = 0;
        while (ti < tlen.size() || ui < ulen.size()) begin
            if (ti < tlen.size() && (m_last || ui >= ulen.size())) begin
                for (int i = 0; i < tlen[ti]; i++) begin
                    exp_d.push_back(tq_d[to + i]); exp_l.push_back(i == tlen[ti] - 1);
                end
                to += tlen[ti]; ti++; m_last = 1'b0;
            end else begin
                for (int i = 0; i < ulen[ui]; i++) begin
                    exp_d.push_back(uq_d[uo + i]); exp_l.push_back(i == ulen[ui] - 1);
                end
                uo += ulen[ui]; ui++; m_last = 1'b1;
            end
        end
        tlen.delete(); ulen.delete();
    endtask

    task automatic run(input int rdy_pct, input bit gaps, input int budget);
        bit t_first = 1'b1, u_first = 1'b1, pend = 1'b0, held = 1'b0, pl = 1'b0, hl = 1'b0;
        logic [W-1:0] pd = '0, hd = '0;
        int cyc = 0;
        while ((exp_d.size() > 0 || pend) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (pend) begin
                chk("latency_valid", ip_data_valid, 1);
                chk("latency_data", ip_data_out, pd);
                chk("latency_last", ip_data_last, pl);
            end
            if (held) begin
                chk("hold_valid", ip_data_valid, 1);
                chk("hold_data", ip_data_out, hd);
                chk("hold_last", ip_data_last, hl);
            end
            tcp_data_valid = tq_d.size() > 0 && (t_first || !gaps || $urandom_range(3) != 0);
            tcp_data_in    = tq_d.size() > 0 ? tq_d[0] : '0;
            tcp_data_last  = tq_d.size() > 0 ? tq_l[0] : 1'b0;
            udp_data_valid = uq_d.size() > 0 && (u_first || !gaps || $urandom_range(3) != 0);
            udp_data_in    = uq_d.size() > 0 ? uq_d[0] : '0;
            udp_data_last  = uq_d.size() > 0 ? uq_l[0] : 1'b0;
            ip_data_ready  = $urandom_range(99) < rdy_pct;
            #1;
            chk("ready_exclusive", tcp_data_ready && udp_data_ready, 0);
            if (ip_data_valid && !ip_data_ready) chk("stall_readies", {tcp_data_ready, udp_data_ready}, 0);
            held = ip_data_valid && !ip_data_ready;
            hd = ip_data_out; hl = ip_data_last;
            if (ip_data_valid && ip_data_ready) begin
                if (exp_d.size() == 0) chk("extra_word", ip_data_valid, 0);
                else begin
                    chk("out_data", ip_data_out, exp_d[0]);
                    chk("out_last", ip_data_last, exp_l[0]);
                    void'(exp_d.pop_front()); void'(exp_l.pop_front());
                end
            end
            pend = 1'b0;
            if (tcp_data_valid && tcp_data_ready) begin
                pend = 1'b1; pd = tq_d[0]; pl = tq_l[0]; t_first = tq_l[0];
                void'(tq_d.pop_front()); void'(tq_l.pop_front());
            end else if (udp_data_valid && udp_data_ready) begin
                pend = 1'b1; pd = uq_d[0]; pl = uq_l[0]; u_first = uq_l[0];
                void'(uq_d.pop_front()); void'(uq_l.pop_front());
            end
        end
        chk("run_words_left", exp_d.size(), 0);
        @(negedge clk);
        tcp_data_valid = 1'b0; udp_data_valid = 1'b0;
        exp_d.delete(); exp_l.delete(); tq_d.delete(); tq_l.delete(); uq_d.delete(); uq_l.delete();
    endtask

    initial begin
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", ip_data_valid, 0);
        chk("rst_last", ip_data_last, 0);
        chk("rst_data", ip_data_out, 0);
        chk("rst_tcp_ready_idle", tcp_data_ready, 0);
        chk("rst_udp_ready_idle", udp_data_ready, 0);
        tcp_data_valid = 1'b1; udp_data_valid = 1'b1;
        #1;
        chk("rst_tie_tcp_ready", tcp_data_ready, 1);
        chk("rst_tie_udp_ready", udp_data_ready, 0);
`ifdef IP_MERGE_PKT_CNT_EN
        chk("rst_tcp_cnt", tcp_pkt_cnt, 0);
        chk("rst_udp_cnt", udp_pkt_cnt, 0);
`endif
        tcp_data_valid = 1'b0; udp_data_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        add_pkt(0, 3); plan(); run(100, 0, 50);

        apply_reset();
        add_pkt(0, 2); add_pkt(1, 2); plan(); run(100, 0, 50);

        drive(0, 0, 0, 1, 32'h0000_0b01, 0, 1);
        chk("mid_u1_udp_ready", udp_data_ready, 1);
        drive(1, 32'h0000_0a01, 1, 1, 32'h0000_0b02, 0, 1);
        chk("mid_u1_out", ip_data_out, 32'h0000_0b01);
        chk("mid_u2_tcp_ready", tcp_data_ready, 0);
        chk("mid_u2_udp_ready", udp_data_ready, 1);
        drive(1, 32'h0000_0a01, 1, 1, 32'h0000_0b03, 1, 1);
        chk("mid_u2_out", ip_data_out, 32'h0000_0b02);
        chk("mid_u3_tcp_ready", tcp_data_ready, 0);
        drive(1, 32'h0000_0a01, 1, 0, 0, 0, 1);
        chk("mid_u3_out", ip_data_out, 32'h0000_0b03);
        chk("mid_u3_last", ip_data_last, 1);
        chk("mid_tcp_granted", tcp_data_ready, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("mid_t1_out", ip_data_out, 32'h0000_0a01);
        chk("mid_t1_last", ip_data_last, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("drain_valid", ip_data_valid, 0);
        m_last = 1'b0;

        drive(1, 32'h0000_0c01, 0, 0, 0, 0, 1);
        chk("stall_b1_ready", tcp_data_ready, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h0000_0c02, 0, 1, 32'h0000_0d01, 1, 0);
            chk("stall_out", ip_data_out, 32'h0000_0c01);
            chk("stall_valid", ip_data_valid, 1);
            chk("stall_both_ready", {tcp_data_ready, udp_data_ready}, 0);
        end
        drive(1, 32'h0000_0c02, 0, 0, 0, 0, 1);
        chk("stall_resume_out", ip_data_out, 32'h0000_0c01);
        chk("stall_resume_ready", tcp_data_ready, 1);
        drive(1, 32'h0000_0c03, 1, 0, 0, 0, 1);
        chk("stall_b2_out", ip_data_out, 32'h0000_0c02);
        chk("stall_b2_last", ip_data_last, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("stall_b3_out", ip_data_out, 32'h0000_0c03);
        chk("stall_b3_last", ip_data_last, 1);
        m_last = 1'b0;

        drive(1, 32'h0000_0e01, 0, 0, 0, 0, 1);
        drive(1, 32'h0000_0e02, 0, 0, 0, 0, 1);
        chk("arst_before_out", ip_data_out, 32'h0000_0e01);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", ip_data_valid, 0);
        chk("arst_data", ip_data_out, 0);
        chk("arst_idle_grant", tcp_data_ready, 1);
        @(negedge clk);
        tcp_data_valid = 1'b0;
        reset = 1'b1;
        m_last = 1'b1;
        add_pkt(0, 4); add_pkt(1, 2); plan(); run(100, 0, 60);

        for (int r = 0; r < 25; r++) begin
            int nt = $urandom_range(0, 4), nu = $urandom_range(0, 4);
            if (nt + nu == 0) nt = 1;
            for (int i = 0; i < nt; i++) add_pkt(0, $urandom_range(1, 4));
            for (int i = 0; i < nu; i++) add_pkt(1, $urandom_range(1, 4));
            plan();
            run($urandom_range(30, 100), 1'b1, 1000);
        end

`ifdef IP_MERGE_PKT_CNT_EN
        apply_reset();
        for (int i = 0; i < 3; i++) add_pkt(0, $urandom_range(1, 3));
        for (int i = 0; i < 2; i++) add_pkt(1, $urandom_range(1, 3));
        plan(); run(100, 0, 100);
        chk("cnt_tcp", tcp_pkt_cnt, 3);
        chk("cnt_udp", udp_pkt_cnt, 2);
        apply_reset();
        @(negedge clk);
        tcp_data_valid = 1'b1; tcp_data_last = 1'b1; ip_data_ready = 1'b1;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        tcp_data_valid = 1'b0;
        #1;
        chk("cnt_tcp_max", tcp_pkt_cnt, 16'hffff);
        drive(1, 32'h1, 1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("cnt_tcp_wrap", tcp_pkt_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
